// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Byte FIFO and launch sequencer feeding a UART transmitter. Host bytes are
//   queued at full clock rate into a circular buffer. They are handed to the
//   transmitter one at a time over a start/txin/txdone handshake. An optional
//   inter-frame gap and a txdone watchdog are included. Overflow and timeout
//   errors are reported through sticky flags.
//
// Ports
//   clk, rst     system clock (rising edge), asynchronous active-high reset
//   wr_en        write strobe, one byte per cycle
//   wr_data      byte to enqueue
//   full, empty  level == DEPTH / level == 0, taken from the level register
//   level        number of bytes currently stored
//   overflow     sticky: a write was dropped because the FIFO was full
//   timeout_err  sticky: txdone did not arrive within TIMEOUT clocks
//   clr_err      clears both sticky flags; a set in the same cycle wins
//   busy         sequencer not idle
//   start        one-cycle launch pulse to the transmitter
//   txin         byte to transmit; held until the next launch
//   txdone       end-of-frame pulse from the transmitter
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 120_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  output logic            timeout_err,
  input  logic            clr_err,
  output logic            busy,
  output logic            start,
  output logic [7:0]      txin,
  input  logic            txdone
);

  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [ADDR_W:0] LEVEL_FULL = DEPTH[ADDR_W:0];
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } state_t;

  state_t state, state_next;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [WD_W-1:0]   wd_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic push, pop;
  logic wd_clr, wd_inc, gap_clr, gap_inc, tmo_set;

  assign full  = (level == LEVEL_FULL);
  assign empty = (level == '0);
  assign busy  = (state != IDLE);

  // A write arriving while full is dropped even when a pop frees a slot
  // on the same edge.
  assign push = wr_en && !full;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    gap_clr    = 1'b0;
    gap_inc    = 1'b0;
    tmo_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          wd_clr     = 1'b1;
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // txdone wins over a watchdog expiry on the same cycle
        if (txdone) begin
          if (GAP_CYCLES > 0) begin
            gap_clr    = 1'b1;
            state_next = GAP;
          end else begin
            state_next = IDLE;
          end
        end else if (wd_cnt == WD_LAST) begin
          tmo_set    = 1'b1;
          state_next = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_next = IDLE;
        else                     gap_inc    = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The FIFO contents are not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      start       <= 1'b0;
      txin        <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;

      start <= pop;
      if (pop) txin <= mem[rd_ptr];

      if (wd_clr)      wd_cnt <= '0;
      else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;

      if (gap_clr)      gap_cnt <= '0;
      else if (gap_inc) gap_cnt <= gap_cnt + 1'b1;

      if (wr_en && full) overflow <= 1'b1;
      else if (clr_err)  overflow <= 1'b0;

      if (tmo_set)      timeout_err <= 1'b1;
      else if (clr_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Drives two uart_tx_fifo instances from the same host stimulus, one with
//   no inter-frame gap and one with a three-clock gap, both with a short
//   watchdog. A timestamp/queue reference model predicts the FIFO contents,
//   launch times and flags; launched bytes go into a per-instance scoreboard
//   that a negedge monitor drains whenever the DUT raises start.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TO    = 50;
  localparam int G1    = 3;

  logic clk = 1'b0;
  logic rst, wr_en, clr_err;
  logic [7:0] wr_data;
  logic [1:0] txdone;

  logic          full [2], empty [2], overflow [2], timeout_err [2];
  logic          busy [2], start [2];
  logic [AW:0]   level [2];
  logic [7:0]    txin [2];

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(AW), .GAP_CYCLES(0), .TIMEOUT(TO)) u_g0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full[0]), .empty(empty[0]), .level(level[0]),
    .overflow(overflow[0]), .timeout_err(timeout_err[0]), .clr_err(clr_err),
    .busy(busy[0]), .start(start[0]), .txin(txin[0]), .txdone(txdone[0])
  );

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(AW), .GAP_CYCLES(G1), .TIMEOUT(TO)) u_g3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full[1]), .empty(empty[1]), .level(level[1]),
    .overflow(overflow[1]), .timeout_err(timeout_err[1]), .clr_err(clr_err),
    .busy(busy[1]), .start(start[1]), .txin(txin[1]), .txdone(txdone[1])
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int td_mode = 0;

  // Reference model: byte queue per instance plus launch/ready timestamps.
  logic [7:0] mq [2][$];
  logic [7:0] sb [2][$];
  int         inflight [2] = '{0, 0};
  int         launch [2]   = '{0, 0};
  int         ready [2]    = '{0, 0};
  int         pop_cyc [2]  = '{-1, -1};
  logic       m_ovf [2]    = '{1'b0, 1'b0};
  logic       m_tmo [2]    = '{1'b0, 1'b0};
  logic [7:0] m_txin [2]   = '{8'h00, 8'h00};

  function automatic int gap_of(input int i);
    return (i == 0) ? 0 : G1;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, i, cyc, act, want);
    end
  endtask

  task automatic model_edge(input int i);
    logic       full_pre;
    logic       tmo_set;
    logic [7:0] b;
    if (rst) begin
      mq[i].delete();
      sb[i].delete();
      inflight[i] = 0;
      ready[i]    = 0;
      pop_cyc[i]  = -1;
      m_ovf[i]    = 1'b0;
      m_tmo[i]    = 1'b0;
      m_txin[i]   = 8'h00;
      return;
    end
    full_pre = (mq[i].size() == DEPTH);
    tmo_set  = 1'b0;
    if (inflight[i] != 0) begin
      if (txdone[i]) begin
        inflight[i] = 0;
        ready[i]    = cyc + gap_of(i) + 1;
      end else if (cyc - launch[i] == TO) begin
        inflight[i] = 0;
        ready[i]    = cyc + 1;
        tmo_set     = 1'b1;
      end
    end else if (cyc >= ready[i] && mq[i].size() > 0) begin
      b = mq[i].pop_front();
      m_txin[i]   = b;
      sb[i].push_back(b);
      inflight[i] = 1;
      launch[i]   = cyc;
      pop_cyc[i]  = cyc;
    end
    if (wr_en && !full_pre) mq[i].push_back(wr_data);
    if (wr_en && full_pre) m_ovf[i] = 1'b1;
    else if (clr_err)      m_ovf[i] = 1'b0;
    if (tmo_set)           m_tmo[i] = 1'b1;
    else if (clr_err)      m_tmo[i] = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) model_edge(i);
    end
  end

  // Monitor: compares every observable output half a cycle after each edge.
  initial begin
    logic [7:0] got;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("level", i, 32'(level[i]), mq[i].size());
        chk("empty", i, 32'(empty[i]), 32'(mq[i].size() == 0));
        chk("full", i, 32'(full[i]), 32'(mq[i].size() == DEPTH));
        chk("overflow", i, 32'(overflow[i]), 32'(m_ovf[i]));
        chk("timeout_err", i, 32'(timeout_err[i]), 32'(m_tmo[i]));
        chk("busy", i, 32'(busy[i]), 32'((inflight[i] != 0) || (cyc < ready[i] - 1)));
        chk("start", i, 32'(start[i]), 32'(pop_cyc[i] == cyc));
        if (start[i]) begin
          if (sb[i].size() == 0) begin
            chk("start_unexpected", i, 32'(1), 32'(0));
          end else begin
            got = sb[i].pop_front();
            chk("txin_launch", i, 32'(txin[i]), 32'(got));
          end
        end else if (pop_cyc[i] == cyc && sb[i].size() > 0) begin
          void'(sb[i].pop_front());
        end
        chk("txin_hold", i, 32'(txin[i]), 32'(m_txin[i]));
      end
    end
  end

  task automatic drive(input logic we, input logic [7:0] d, input logic clr);
    wr_en   = we;
    wr_data = d;
    clr_err = clr;
    for (int i = 0; i < 2; i++)
      txdone[i] = (td_mode == 1) && busy[i] && ($urandom_range(0, 3) == 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; clr_err = 1'b0; txdone = '0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;

    // single byte, then let the transmitter answer
    td_mode = 0;
    drive(1'b1, 8'hA5, 1'b0);
    repeat (6) drive(1'b0, 8'h00, 1'b0);
    td_mode = 1;
    repeat (20) drive(1'b0, 8'h00, 1'b0);

    // burst to full while txdone is held off, then a write into a full FIFO
    td_mode = 0;
    for (int k = 0; k < 17; k++) drive(1'b1, 8'(k), 1'b0);
    drive(1'b1, 8'hFF, 1'b0);
    repeat (2) drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    td_mode = 1;
    repeat (250) drive(1'b0, 8'h00, 1'b0);

    // random interleaving of writes, completions and error clears
    repeat (400) drive($urandom_range(0, 2) == 0, 8'($urandom), $urandom_range(0, 40) == 0);
    repeat (250) drive(1'b0, 8'h00, 1'b0);

    // watchdog: nothing answers, each queued byte times out in turn
    td_mode = 0;
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 3; k++) drive(1'b1, 8'(8'h30 + k), 1'b0);
    repeat (170) drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    for (int k = 0; k < 17; k++) drive(1'b1, 8'(8'h40 + k), 1'b0);
    drive(1'b1, 8'h77, 1'b1);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    td_mode = 1;
    repeat (250) drive(1'b0, 8'h00, 1'b0);

    // reset in the middle of a frame with bytes still queued
    td_mode = 0;
    for (int k = 0; k < 4; k++) drive(1'b1, 8'(8'h60 + k), 1'b0);
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("async_rst_level", i, 32'(level[i]), 32'(0));
      chk("async_rst_empty", i, 32'(empty[i]), 32'(1));
      chk("async_rst_start", i, 32'(start[i]), 32'(0));
      chk("async_rst_busy", i, 32'(busy[i]), 32'(0));
    end
    repeat (2) drive(1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    repeat (20) drive(1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h5A, 1'b0);
    td_mode = 1;
    repeat (40) drive(1'b0, 8'h00, 1'b0);

    for (int i = 0; i < 2; i++) chk("scoreboard_drained", i, sb[i].size(), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
